// File: rtl/hololink_user_apb_regs.sv
// hololink_user_apb_regs: APB completer for a Hololink user register port.
// Registers: ID, SCRATCH, CTRL, STATUS (sticky W1C events) and a free-running CNT.
// Optional feature macro USER_REG_IRQ_EN adds IRQ_MASK at 0x14 and drives o_irq.
module hololink_user_apb_regs #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned EVT_W    = 8,
  parameter int unsigned RD_WAIT  = 1,
  parameter logic [31:0] ID_VALUE = 32'h484C_0001
) (
  input  logic              i_apb_clk,
  input  logic              i_apb_rst_n,
  input  logic              i_apb_psel,
  input  logic              i_apb_penable,
  input  logic              i_apb_pwrite,
  input  logic [ADDR_W-1:0] i_apb_paddr,
  input  logic [31:0]       i_apb_pwdata,
  output logic              o_apb_pready,
  output logic [31:0]       o_apb_prdata,
  output logic              o_apb_pslverr,
  input  logic [EVT_W-1:0]  i_event,
  output logic [31:0]       o_ctrl,
  output logic              o_irq
);

  localparam logic [7:0] OFF_ID      = 8'h00;
  localparam logic [7:0] OFF_SCRATCH = 8'h04;
  localparam logic [7:0] OFF_CTRL    = 8'h08;
  localparam logic [7:0] OFF_STATUS  = 8'h0C;
  localparam logic [7:0] OFF_CNT     = 8'h10;
`ifdef USER_REG_IRQ_EN
  localparam logic [7:0] OFF_MASK    = 8'h14;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  logic [2:0]         r_wait_cnt;
  logic [7:0]         r_addr;
  logic               r_write;
  logic [31:0]        r_wdata;
  logic               r_pready;
  logic [31:0]        r_prdata;
  logic               r_pslverr;
  logic [31:0]        r_scratch;
  logic [31:0]        r_ctrl;
  logic [EVT_W-1:0]   r_status;
  logic [31:0]        r_cnt;
`ifdef USER_REG_IRQ_EN
  logic [31:0]        r_mask;
  logic               r_irq;
`endif

  logic [7:0]         w_addr;
  logic               w_hit;
  logic [31:0]        w_rdata;
  logic               w_commit;
  logic [EVT_W-1:0]   w_clr;
  logic               w_unused_paddr;

  // Only the low byte of the address is decoded
  assign w_unused_paddr = ^i_apb_paddr;

  // Decode address: live bus in IDLE (RESP entered at setup edge), latched otherwise
  assign w_addr = (r_state == S_IDLE) ? i_apb_paddr[7:0] : r_addr;

  // Register map decode and read mux; misaligned offsets never match
  always_comb begin
    w_hit   = 1'b0;
    w_rdata = 32'd0;
    case (w_addr)
      OFF_ID:      begin w_hit = 1'b1; w_rdata = ID_VALUE;      end
      OFF_SCRATCH: begin w_hit = 1'b1; w_rdata = r_scratch;     end
      OFF_CTRL:    begin w_hit = 1'b1; w_rdata = r_ctrl;        end
      OFF_STATUS:  begin w_hit = 1'b1; w_rdata = 32'(r_status); end
      OFF_CNT:     begin w_hit = 1'b1; w_rdata = r_cnt;         end
`ifdef USER_REG_IRQ_EN
      OFF_MASK:    begin w_hit = 1'b1; w_rdata = r_mask;        end
`endif
      default:     begin w_hit = 1'b0; w_rdata = 32'd0;         end
    endcase
  end

  // A write lands on the completing edge of a non-error transfer
  assign w_commit = (r_state == S_RESP) && i_apb_psel && i_apb_penable &&
                    r_write && !r_pslverr;
  assign w_clr    = (w_commit && (r_addr == OFF_STATUS)) ? r_wdata[EVT_W-1:0] : '0;

  // APB transfer FSM with registered response
  always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
    if (!i_apb_rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 3'd0;
      r_addr     <= 8'd0;
      r_write    <= 1'b0;
      r_wdata    <= 32'd0;
      r_pready   <= 1'b0;
      r_prdata   <= 32'd0;
      r_pslverr  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_apb_psel && !i_apb_penable) begin
            r_addr  <= i_apb_paddr[7:0];
            r_write <= i_apb_pwrite;
            r_wdata <= i_apb_pwdata;
            if (!i_apb_pwrite && (RD_WAIT != 0)) begin
              r_state    <= S_WAIT;
              r_wait_cnt <= 3'(RD_WAIT - 1);
            end else begin
              r_state   <= S_RESP;
              r_pready  <= 1'b1;
              r_prdata  <= i_apb_pwrite ? 32'd0 : w_rdata;
              r_pslverr <= !w_hit;
            end
          end
        end
        S_WAIT: begin
          if (!i_apb_psel) begin
            r_state <= S_IDLE;
          end else if (r_wait_cnt == 3'd0) begin
            r_state   <= S_RESP;
            r_pready  <= 1'b1;
            r_prdata  <= w_rdata;
            r_pslverr <= !w_hit;
          end else begin
            r_wait_cnt <= r_wait_cnt - 3'd1;
          end
        end
        S_RESP: begin
          if (!i_apb_psel || i_apb_penable) begin
            r_state   <= S_IDLE;
            r_pready  <= 1'b0;
            r_prdata  <= 32'd0;
            r_pslverr <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_pready <= 1'b0;
        end
      endcase
    end
  end

  // SCRATCH and CTRL writable registers
  always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
    if (!i_apb_rst_n) begin
      r_scratch <= 32'd0;
      r_ctrl    <= 32'd0;
    end else if (w_commit) begin
      if (r_addr == OFF_SCRATCH) r_scratch <= r_wdata;
      if (r_addr == OFF_CTRL)    r_ctrl    <= r_wdata;
    end
  end

  // Sticky event capture; a new event beats a same-cycle clear
  always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
    if (!i_apb_rst_n) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~w_clr) | i_event;
    end
  end

  // Free-running counter; a software load beats the increment
  always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
    if (!i_apb_rst_n) begin
      r_cnt <= 32'd0;
    end else if (w_commit && (r_addr == OFF_CNT)) begin
      r_cnt <= r_wdata;
    end else if (r_ctrl[0]) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

`ifdef USER_REG_IRQ_EN
  // Interrupt mask and registered interrupt line
  always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
    if (!i_apb_rst_n) begin
      r_mask <= 32'd0;
      r_irq  <= 1'b0;
    end else begin
      if (w_commit && (r_addr == OFF_MASK)) r_mask <= r_wdata;
      r_irq <= |(r_status & r_mask[EVT_W-1:0]);
    end
  end
  assign o_irq = r_irq;
`else
  assign o_irq = 1'b0;
`endif

  assign o_apb_pready  = r_pready;
  assign o_apb_prdata  = r_prdata;
  assign o_apb_pslverr = r_pslverr;
  assign o_ctrl        = r_ctrl;

endmodule

// File: tb/tb_hololink_user_apb_regs.sv
// Bench for hololink_user_apb_regs: directed APB traffic against a register-level model.
`timescale 1ns/1ps
module tb_hololink_user_apb_regs;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned EVT_W   = 8;
  localparam int unsigned RD_WAIT = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic              pready;
  logic [31:0]       prdata;
  logic              pslverr;
  logic [EVT_W-1:0]  ev;
  logic [31:0]       ctrl;
  logic              irq;

  hololink_user_apb_regs #(
    .ADDR_W(ADDR_W), .EVT_W(EVT_W), .RD_WAIT(RD_WAIT), .ID_VALUE(32'h484C_0001)
  ) dut (
    .i_apb_clk(clk), .i_apb_rst_n(rst_n),
    .i_apb_psel(psel), .i_apb_penable(penable), .i_apb_pwrite(pwrite),
    .i_apb_paddr(paddr), .i_apb_pwdata(pwdata),
    .o_apb_pready(pready), .o_apb_prdata(prdata), .o_apb_pslverr(pslverr),
    .i_event(ev), .o_ctrl(ctrl), .o_irq(irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Register-level model: current values, values before the last edge, pending commit
  logic [31:0]      m_scratch, m_ctrl, m_cnt, m_mask;
  logic [EVT_W-1:0] m_status;
  logic             m_irq;
  logic [31:0]      s_scratch, s_ctrl, s_cnt, s_mask;
  logic [EVT_W-1:0] s_status;
  bit               c_vld;
  logic [7:0]       c_addr;
  logic [31:0]      c_data;

  function automatic bit mapped(input logic [ADDR_W-1:0] a);
    case (a[7:0])
      8'h00, 8'h04, 8'h08, 8'h0C, 8'h10: return 1'b1;
`ifdef USER_REG_IRQ_EN
      8'h14: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] snap_read(input logic [7:0] off);
    case (off)
      8'h00:   return 32'h484C_0001;
      8'h04:   return s_scratch;
      8'h08:   return s_ctrl;
      8'h0C:   return 32'(s_status);
      8'h10:   return s_cnt;
      8'h14:   return s_mask;
      default: return 32'd0;
    endcase
  endfunction

  // Model advances one clock at a time
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_scratch = 0; m_ctrl = 0; m_cnt = 0; m_mask = 0; m_status = '0; m_irq = 0;
      s_scratch = 0; s_ctrl = 0; s_cnt = 0; s_mask = 0; s_status = '0;
      c_vld = 0;
    end else begin
      logic [EVT_W-1:0] clr;
      s_scratch = m_scratch; s_ctrl = m_ctrl; s_cnt = m_cnt; s_mask = m_mask; s_status = m_status;
      m_irq = |(m_status & m_mask[EVT_W-1:0]);
      clr = (c_vld && c_addr == 8'h0C) ? c_data[EVT_W-1:0] : '0;
      m_status = (m_status & ~clr) | ev;
      if (c_vld && c_addr == 8'h10) m_cnt = c_data;
      else if (m_ctrl[0])           m_cnt = m_cnt + 1;
      if (c_vld && c_addr == 8'h04) m_scratch = c_data;
      if (c_vld && c_addr == 8'h08) m_ctrl = c_data;
      if (c_vld && c_addr == 8'h14) m_mask = c_data;
      c_vld = 0;
    end
  end

  // Continuous comparison of the register-driven outputs
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("o_ctrl", ctrl, m_ctrl);
      chk("o_irq", 32'(irq), 32'(m_irq));
    end
  end

  // One APB transfer with latency, error and read-data checks against the model
  task automatic apb(input bit wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err);
    int cyc;
    bit done;
    bit exp_err;
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wdata; cyc = 1;
    @(posedge clk); #1;
    penable = 1; cyc = 2; done = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      if (pready) begin
        done = 1;
        exp_err = !mapped(addr);
        chk("pslverr", 32'(pslverr), 32'(exp_err));
        chk("latency", 32'(cyc), wr ? 32'd2 : 32'(2 + RD_WAIT));
        if (!wr) chk("prdata", prdata, exp_err ? 32'd0 : snap_read(addr[7:0]));
        else if (!exp_err) begin c_vld = 1; c_addr = addr[7:0]; c_data = wdata; end
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!done) chk("pready_timeout", 32'(pready), 32'd1);
    rdata = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 0; penable = 0;
  endtask

  task automatic wr32(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    logic [31:0] rd; logic e;
    apb(1'b1, a, d, rd, e);
  endtask

  task automatic pulse(input logic [EVT_W-1:0] v);
    @(posedge clk); #1; ev = v;
    @(posedge clk); #1; ev = '0;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; ev = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_ctrl", ctrl, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_n = 1;
    chk_en = 1;

    apb(0, 16'h0000, 0, rd, er);
    chk("id_lit", rd, 32'h484C_0001);
    chk("id_err_lit", 32'(er), 32'd0);

    wr32(16'h0004, 32'hDEAD_BEEF);
    apb(0, 16'h0004, 0, rd, er);
    chk("scratch_lit", rd, 32'hDEAD_BEEF);

    apb(0, 16'h0020, 0, rd, er);
    chk("err20_lit", 32'(er), 32'd1);
    chk("err20_data_lit", rd, 32'd0);
    apb(0, 16'h0006, 0, rd, er);
    chk("err06_lit", 32'(er), 32'd1);
    wr32(16'h0020, 32'h1111_1111);
    wr32(16'h0006, 32'h2222_2222);
    wr32(16'hAB04, 32'h0BAD_F00D);
    apb(0, 16'h0004, 0, rd, er);
    chk("scratch_upper_ignored_lit", rd, 32'h0BAD_F00D);
    wr32(16'h0004, 32'hDEAD_BEEF);

    pulse(8'h08);
    apb(0, 16'h000C, 0, rd, er);
    chk("status_lit", rd, 32'h8);
    ev = 8'h08;
    wr32(16'h000C, 32'h8);
    ev = '0;
    apb(0, 16'h000C, 0, rd, er);
    chk("status_setwins_lit", rd, 32'h8);
    wr32(16'h000C, 32'hFFFF_FFFF);
    pulse(8'hA5);
    wr32(16'h000C, 32'h21);
    apb(0, 16'h000C, 0, rd, er);
    chk("status_w1c_lit", rd, 32'h84);
    wr32(16'h000C, 32'hFF);

    wr32(16'h0008, 32'h1234_5670);
    apb(0, 16'h0008, 0, rd, er);
    chk("ctrl_lit", rd, 32'h1234_5670);

    wr32(16'h0010, 32'hFFFF_FFFE);
    wr32(16'h0008, 32'h1);
    wr32(16'h0008, 32'h0);
    apb(0, 16'h0010, 0, rd, er);
    chk("cnt_wrap_lit", rd, 32'h1);
    repeat (5) @(posedge clk);
    apb(0, 16'h0010, 0, rd, er);
    chk("cnt_hold_lit", rd, 32'h1);
    wr32(16'h0008, 32'h1);
    apb(0, 16'h0010, 0, rd, er);
    wr32(16'h0010, 32'h100);
    apb(0, 16'h0010, 0, rd, er);
    wr32(16'h0008, 32'h0);

    // Write abandoned by dropping psel while the response is pending
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 16'h0004; pwdata = 32'h5555_5555;
    @(posedge clk); #1;
    psel = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_pready_lit", 32'(pready), 32'd0);
    apb(0, 16'h0004, 0, rd, er);
    chk("abort_nocommit_lit", rd, 32'hDEAD_BEEF);

`ifdef USER_REG_IRQ_EN
    wr32(16'h0014, 32'h1);
    apb(0, 16'h0014, 0, rd, er);
    chk("mask_lit", rd, 32'h1);
    pulse(8'h02);
    @(posedge clk); #1;
    chk("irq_masked_lit", 32'(irq), 32'd0);
    pulse(8'h01);
    @(posedge clk); #1;
    chk("irq_set_lit", 32'(irq), 32'd1);
    wr32(16'h000C, 32'h1);
    @(posedge clk); #1;
    chk("irq_clr_lit", 32'(irq), 32'd0);
`else
    apb(0, 16'h0014, 0, rd, er);
    chk("mask_unmapped_lit", 32'(er), 32'd1);
`endif

    // Asynchronous reset during the read wait phase
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 0; paddr = 16'h0004;
    @(posedge clk); #1;
    penable = 1;
    #2;
    rst_n = 0;
    #1;
    chk("rstmid_pready_lit", 32'(pready), 32'd0);
    chk("rstmid_prdata_lit", prdata, 32'd0);
    psel = 0; penable = 0;
    @(posedge clk); #1;
    rst_n = 1;
    apb(0, 16'h0004, 0, rd, er);
    chk("rstmid_scratch_lit", rd, 32'd0);

    // Asynchronous reset while a write response is pending
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 16'h0004; pwdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    chk("rstwr_pready_lit", 32'(pready), 32'd1);
    #1;
    rst_n = 0;
    #1;
    psel = 0; penable = 0;
    @(posedge clk); #1;
    rst_n = 1;
    apb(0, 16'h0004, 0, rd, er);
    chk("rstwr_discard_lit", rd, 32'd0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
